// File: rtl/branch_controller_pkg.sv
// rtl/branch_controller_pkg.sv - shared encodings for the branch controller
//
// Purpose: op encodings, condition codes, flag bit positions, the default
//          return-address-stack depth and the condition evaluation helper.
// Ports:   none (package).
package branch_controller_pkg;

  localparam int RAS_DEPTH_DEFAULT = 8;

  // Instruction op encodings; 5..7 decode as NOP.
  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_BCOND = 3'd1;
  localparam logic [2:0] OP_JUMP  = 3'd2;
  localparam logic [2:0] OP_CALL  = 3'd3;
  localparam logic [2:0] OP_RET   = 3'd4;

  // Flag register layout {N,Z,F,L,C}.
  localparam int FLAG_N = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_L = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [3:0] {
    CC_EQ = 4'd0,
    CC_NE = 4'd1,
    CC_CS = 4'd2,
    CC_CC = 4'd3,
    CC_HI = 4'd4,
    CC_LS = 4'd5,
    CC_GT = 4'd6,
    CC_LE = 4'd7,
    CC_FS = 4'd8,
    CC_FC = 4'd9,
    CC_LO = 4'd10,
    CC_HS = 4'd11,
    CC_LT = 4'd12,
    CC_GE = 4'd13,
    CC_UC = 4'd14,
    CC_NV = 4'd15
  } cond_e;

  // True when condition code cc holds for flag word f.
  function automatic logic cond_true(input logic [3:0] cc, input logic [4:0] f);
    logic n, z, fl, l, c;
    logic r;
    n  = f[FLAG_N];
    z  = f[FLAG_Z];
    fl = f[FLAG_F];
    l  = f[FLAG_L];
    c  = f[FLAG_C];
    case (cond_e'(cc))
      CC_EQ:   r = z;
      CC_NE:   r = !z;
      CC_CS:   r = c;
      CC_CC:   r = !c;
      CC_HI:   r = l;
      CC_LS:   r = !l;
      CC_GT:   r = n;
      CC_LE:   r = !n;
      CC_FS:   r = fl;
      CC_FC:   r = !fl;
      CC_LO:   r = !l && !z;
      CC_HS:   r = l || z;
      CC_LT:   r = !n && !z;
      CC_GE:   r = n || z;
      CC_UC:   r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/branch_ras.sv
// rtl/branch_ras.sv - return-address stack with saturating occupancy
//
// Purpose: LIFO of return addresses. A push on a full stack and a pop on an
//          empty stack are ignored; the caller decides how to flag them.
//          Entry storage is not reset, only the occupancy count.
// Ports:   clk, reset  - clock, synchronous active-high reset
//          push, pop   - stack operations (simultaneous push+pop is a no-op)
//          din         - value pushed
//          dout        - current top entry (valid when !empty)
//          empty, full - occupancy status
module branch_ras
  import branch_controller_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH_DEFAULT,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   top;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH[PTR_W:0]);
  assign do_push = push && !pop && !full;
  assign do_pop  = pop && !push && !empty;

  // Top entry sits one below the occupancy count.
  assign top  = count - 1'b1;
  assign dout = mem[top[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (do_push) begin
      count <= count + 1'b1;
    end else if (do_pop) begin
      count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[count[PTR_W-1:0]] <= din;
    end
  end

endmodule

// File: rtl/branch_controller.sv
// rtl/branch_controller.sv - branch decision unit with optional return-address stack
//
// Purpose: decodes BCOND/JUMP/CALL/RET, evaluates conditions on the
//          registered flags and issues a registered one-cycle redirect.
//          The instruction following a redirect is in the branch shadow and
//          is ignored. Configuration macro BRANCH_RAS_EN builds the return
//          address stack; without it CALL acts as JUMP, RET as NOP and the
//          overflow/underflow flags read 0.
// Ports:   clk, reset             - clock, synchronous active-high reset
//          instr_valid, pc_in, op - instruction qualifier, PC and opcode
//          cond, disp, tgt_in     - condition code, signed displacement, target
//          flags_in, flags_we     - ALU flags {N,Z,F,L,C} and their write enable
//          branch_addr            - redirect target (held when not taken)
//          sel_next, flush        - one-cycle redirect / squash pulse
//          ras_ovf, ras_unf       - sticky stack overflow / underflow
module branch_controller
  import branch_controller_pkg::*;
#(
  parameter int RAS_DEPTH = RAS_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [15:0] pc_in,
  input  logic [2:0]  op,
  input  logic [3:0]  cond,
  input  logic [7:0]  disp,
  input  logic [15:0] tgt_in,
  input  logic [4:0]  flags_in,
  input  logic        flags_we,
  output logic [15:0] branch_addr,
  output logic        sel_next,
  output logic        flush,
  output logic        ras_ovf,
  output logic        ras_unf
);

  if (RAS_DEPTH < 2 || RAS_DEPTH > 16 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("RAS_DEPTH must be a power of 2 in 2..16");
  end

  logic [4:0]  flags_q;
  logic        accept;
  logic [15:0] bcond_addr;
  logic        take;
  logic [15:0] take_addr;

  // sel_next high means the instruction now presented is in the shadow.
  assign accept     = instr_valid && !sel_next;
  assign bcond_addr = pc_in + {{8{disp[7]}}, disp};

`ifdef BRANCH_RAS_EN
  logic        ras_push;
  logic        ras_pop;
  logic        ras_empty;
  logic        ras_full;
  logic [15:0] ras_dout;
  logic [15:0] ret_addr;
  logic        ovf_set;
  logic        unf_set;

  assign ret_addr = pc_in + 16'd1;

  branch_ras #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (16)
  ) u_ras (
    .clk   (clk),
    .reset (reset),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (ret_addr),
    .dout  (ras_dout),
    .empty (ras_empty),
    .full  (ras_full)
  );
`endif

  always_comb begin
    take      = 1'b0;
    take_addr = branch_addr;
`ifdef BRANCH_RAS_EN
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
`endif
    if (accept) begin
      case (op)
        OP_BCOND: begin
          if (cond_true(cond, flags_q)) begin
            take      = 1'b1;
            take_addr = bcond_addr;
          end
        end
        OP_JUMP: begin
          take      = 1'b1;
          take_addr = tgt_in;
        end
        OP_CALL: begin
          // The jump is taken even when the return address cannot be saved.
          take      = 1'b1;
          take_addr = tgt_in;
`ifdef BRANCH_RAS_EN
          if (ras_full) begin
            ovf_set  = 1'b1;
          end else begin
            ras_push = 1'b1;
          end
`endif
        end
        OP_RET: begin
`ifdef BRANCH_RAS_EN
          if (ras_empty) begin
            unf_set   = 1'b1;
          end else begin
            take      = 1'b1;
            take_addr = ras_dout;
            ras_pop   = 1'b1;
          end
`endif
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q     <= '0;
      branch_addr <= '0;
      sel_next    <= 1'b0;
      flush       <= 1'b0;
    end else begin
      // Conditions above saw the old flags; the new ones apply next cycle.
      if (flags_we) begin
        flags_q <= flags_in;
      end
      sel_next <= take;
      flush    <= take;
      if (take) begin
        branch_addr <= take_addr;
      end
    end
  end

`ifdef BRANCH_RAS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
    end else begin
      if (ovf_set) begin
        ras_ovf <= 1'b1;
      end
      if (unf_set) begin
        ras_unf <= 1'b1;
      end
    end
  end
`else
  assign ras_ovf = 1'b0;
  assign ras_unf = 1'b0;
`endif

endmodule

// File: doc/branch_controller.md
BRANCH_CONTROLLER -- requirements
Module: branch_controller

Interface
REQ-001 Parameter RAS_DEPTH, default 8: return-address-stack entries, a power of 2, range 2..16.
REQ-002 clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 instr_valid  input  1  op/cond/disp/tgt_in/pc_in are valid this cycle.
REQ-005 pc_in  input  16  address of the current instruction, taken from the program counter output.
REQ-006 op  input  3  0 NOP, 1 BCOND, 2 JUMP, 3 CALL, 4 RET; values 5-7 are treated as NOP.
REQ-007 cond  input  4  condition code for BCOND.
REQ-008 disp  input  8  signed branch displacement.
REQ-009 tgt_in  input  16  absolute target for JUMP/CALL.
REQ-010 flags_in  input  5  {N,Z,F,L,C} from the ALU.
REQ-011 flags_we  input  1  writes flags_in into the flag register.
REQ-012 branch_addr  output  16  redirect target, sent to the program counter branch input.
REQ-013 sel_next  output  1  one-cycle pulse that selects branch_addr into the program counter.
REQ-014 flush  output  1  squash indicator; equals sel_next.
REQ-015 ras_ovf  output  1  sticky flag: a push was attempted on a full stack.
REQ-016 ras_unf  output  1  sticky flag: a pop was attempted on an empty stack.

Function
REQ-017 All outputs are registered, so a decision made in cycle T appears on the outputs in cycle T+1.
REQ-018 An instruction accepted while sel_next=1 is in the branch shadow; it is ignored, with no flag, stack or output effect.
REQ-019 BCOND taken: branch_addr = pc_in + sign-extended disp, computed modulo 2^16.
REQ-020 JUMP is always taken, with branch_addr = tgt_in.
REQ-021 CALL is always taken: branch_addr = tgt_in, and pc_in+1 (modulo 2^16) is pushed onto the stack.
REQ-022 RET on a non-empty stack is taken: it pops the top entry and drives that value on branch_addr.
REQ-023 Condition codes, evaluated on the registered flags:
- 0 EQ: Z
- 1 NE: !Z
- 2 CS: C
- 3 CC: !C
- 4 HI: L
- 5 LS: !L
- 6 GT: N
- 7 LE: !N
- 8 FS: F
- 9 FC: !F
- 10 LO: !L&!Z
- 11 HS: L|Z
- 12 LT: !N&!Z
- 13 GE: N|Z
- 14 UC: 1
- 15 NV: 0
REQ-024 When flags_we and a BCOND occur in the same cycle, the condition uses the old flag value; the new flags are visible from the next cycle.
REQ-025 When no branch is taken, sel_next=0 and branch_addr holds its previous value.
REQ-026 CALL on a full stack: the push is dropped, ras_ovf is set, and the jump is still taken.
REQ-027 RET on an empty stack: ras_unf is set, sel_next stays 0, and execution falls through.
REQ-028 Stack pointer wrap-around is never permitted; the occupancy count saturates at 0 and at RAS_DEPTH.
REQ-029 instr_valid=0 behaves as NOP; the flag register still updates on flags_we.

Reset
REQ-030 While reset is high, the following clear to 0 on the next clock edge:
- branch_addr, sel_next and flush
- ras_ovf and ras_unf
- the flag register
- the stack occupancy
REQ-031 A reset that coincides with a decision cancels that decision, so sel_next=0 in the following cycle.
REQ-032 Stack entry contents are not reset.

Configuration
REQ-033 With macro BRANCH_RAS_EN defined, the return-address stack and the overflow/underflow flags behave as stated above.
REQ-034 With BRANCH_RAS_EN undefined:
- CALL behaves as JUMP.
- RET behaves as NOP.
- ras_ovf and ras_unf are tied to 0.
- No stack storage is built.

Structure
REQ-035 A shared package holds:
- the op encoding constants
- the condition code constants
- the flag bit indices
- the RAS_DEPTH default
REQ-036 The stack is a sub-module named branch_ras, with push, pop, data in, data out, empty and full ports, plus clk and reset.

Verification
REQ-037 Scenario 1: flags_we with Z=1, then BCOND EQ with pc_in=0x0010 and disp=0xFC -> one cycle later branch_addr=0x000C and sel_next=1 for exactly one cycle.
REQ-038 Scenario 2: flags_we with Z=0, and BCOND EQ in the same cycle while the prior Z=1 -> taken on the old flags; the next BCOND EQ -> not taken.
REQ-039 Scenario 3: CALL with pc_in=0x0100 and tgt_in=0x0200, then RET outside the shadow -> branch_addr=0x0200 then 0x0101.
REQ-040 Scenario 4: RAS_DEPTH+1 CALLs -> ras_ovf=1 and all jumps taken; RAS_DEPTH+1 RETs -> the last RET is not taken and ras_unf=1.
REQ-041 Scenario 5: JUMP to 0x0300 immediately followed by JUMP to 0x0400 -> only 0x0300 is issued, because the second JUMP is squashed in the shadow.
REQ-042 Scenario 6: reset asserted in the same cycle as a taken JUMP -> all outputs are 0 the next cycle, and a following RET sets ras_unf.
